mem_rsp_router: RTL and testbench

- Sits between the round-robin request arbiter and a single-port memory with in-order responses.
- Passes the arbitrated request to memory and stalls it when the outstanding limit is reached.
- Records the winning input index of every accepted request in an index FIFO.
- Routes each returning memory response, registered, back to the input that issued it.

---
 rtl/mem_rsp_router.sv | 105 ++++++++++
 tb/tb_mem_rsp_router.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_rsp_router.sv
// Response router: forwards arbitrated requests to memory, tracks the issuing
// input of each accepted request and steers in-order responses back to it.
module mem_rsp_router #(
  parameter int unsigned NumIn          = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned IdxWidth      = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 arb_req_i,
  input  logic [IdxWidth-1:0]  arb_idx_i,
  output logic                 arb_gnt_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [NumIn-1:0]     rsp_valid_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 err_o
);

  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic [NumIn-1:0]     rsp_valid_q;
  logic [DataWidth-1:0] rsp_data_q;
  logic                 err_q;
  logic [IdxWidth-1:0]  idx_mem [MaxOutstanding];

  logic                 full, empty, push, pop, spurious;
  logic [IdxWidth-1:0]  head_idx;
  logic [NumIn-1:0]     head_onehot;

  // Handshake qualification; full/empty come from the registered count only,
  // so a slot freed this cycle is not reusable until the next one.
  always_comb begin
    full      = (cnt_q == FullCnt);
    empty     = (cnt_q == '0);
    mem_req_o = arb_req_i & ~full;
    arb_gnt_o = mem_gnt_i & ~full;
    push      = arb_req_i & mem_gnt_i & ~full & ~flush_i;
    pop       = mem_rvalid_i & ~empty & ~flush_i;
    spurious  = mem_rvalid_i & empty & ~flush_i;
    head_idx  = idx_mem[rd_ptr_q];
  end

  // Decode the oldest recorded index into a per-input valid.
  if (NumIn == 1) begin : g_single
    assign head_onehot = 1'b1;
  end else begin : g_multi
    always_comb begin
      head_onehot = '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        if (head_idx == IdxWidth'(i)) head_onehot[i] = 1'b1;
      end
    end
  end

  // Index storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk_i) begin
    if (push) idx_mem[wr_ptr_q] <= arb_idx_i;
  end

  // Pointers, count, registered response and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
      rsp_valid_q <= pop ? head_onehot : '0;
      if (pop)      rsp_data_q <= mem_rdata_i;
      if (spurious) err_q      <= 1'b1;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_mem_rsp_router.sv
// Bench for mem_rsp_router: directed scenarios plus random traffic, checked
// against a queue-based model of outstanding requests.
module tb_mem_rsp_router;

  localparam int unsigned NumIn    = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned MaxOut   = 8;
  localparam int unsigned IdxWidth = 2;
  localparam int unsigned CntWidth = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic                arb_req_i;
  logic [IdxWidth-1:0] arb_idx_i;
  logic                arb_gnt_o;
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [DW-1:0]       mem_rdata_i;
  logic [NumIn-1:0]    rsp_valid_o;
  logic [DW-1:0]       rsp_data_o;
  logic [CntWidth-1:0] outstanding_o;
  logic                err_o;

  mem_rsp_router #(.NumIn(NumIn), .DataWidth(DW), .MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .arb_req_i(arb_req_i), .arb_idx_i(arb_idx_i), .arb_gnt_o(arb_gnt_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model: queue of issuing indices in grant order plus expected output regs.
  int          mq[$];
  logic [3:0]  m_valid;
  logic [31:0] m_data;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = '0;
    m_data  = '0;
    m_err   = 1'b0;
  endtask

  task automatic drive(input logic req, input int idx, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic fl);
    arb_req_i    = req;
    arb_idx_i    = IdxWidth'(idx);
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    flush_i      = fl;
  endtask

  // One clock: check request path, advance model, check registered outputs.
  task automatic cycle();
    bit full;
    bit did_pop;
    int head;
    #1;
    full = (mq.size() == MaxOut);
    chk("mem_req", 64'(mem_req_o), 64'(arb_req_i && !full));
    chk("arb_gnt", 64'(arb_gnt_o), 64'(mem_gnt_i && !full));
    if (flush_i) begin
      mq.delete();
      m_valid = '0;
      m_err   = 1'b0;
    end else begin
      did_pop = mem_rvalid_i && (mq.size() > 0);
      if (mem_rvalid_i && mq.size() == 0) m_err = 1'b1;
      if (did_pop) begin
        head    = mq.pop_front();
        m_valid = 4'(1 << head);
        m_data  = mem_rdata_i;
      end else begin
        m_valid = '0;
      end
      if (arb_req_i && mem_gnt_i && !full) mq.push_back(int'(arb_idx_i));
    end
    @(posedge clk_i);
    #1;
    chk("outstanding", 64'(outstanding_o), 64'(mq.size()));
    chk("rsp_valid",   64'(rsp_valid_o),   64'(m_valid));
    chk("rsp_data",    64'(rsp_data_o),    64'(m_data));
    chk("err",         64'(err_o),         64'(m_err));
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0);
    cycle();
  endtask

  task automatic grant(input int idx);
    drive(1, idx, 1, 0, 32'h0, 0);
    cycle();
  endtask

  task automatic respond();
    drive(0, 0, 0, 1, $urandom, 0);
    cycle();
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0);
    model_reset();
    #2;
    chk("reset_outstanding", 64'(outstanding_o), 64'd0);
    chk("reset_rsp_valid",   64'(rsp_valid_o),   64'd0);
    chk("reset_rsp_data",    64'(rsp_data_o),    64'd0);
    chk("reset_err",         64'(err_o),         64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Single request from input 2, response three cycles later.
    grant(2);
    chk("single_cnt1", 64'(outstanding_o), 64'd1);
    idle();
    idle();
    drive(0, 0, 0, 1, 32'hA5A5_0001, 0);
    cycle();
    chk("single_valid", 64'(rsp_valid_o), 64'b0100);
    chk("single_data",  64'(rsp_data_o),  64'hA5A5_0001);
    chk("single_cnt0",  64'(outstanding_o), 64'd0);

    // Fill to the limit, then confirm requests are stalled.
    for (int i = 0; i < 8; i++) grant(i % 4);
    chk("fill_cnt", 64'(outstanding_o), 64'd8);
    drive(1, 1, 1, 0, 32'h0, 0);
    #1;
    chk("full_mem_req", 64'(mem_req_o), 64'd0);
    chk("full_arb_gnt", 64'(arb_gnt_o), 64'd0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      respond();
      chk("drain_onehot", 64'(rsp_valid_o), 64'(1 << (i % 4)));
    end
    chk("drain_cnt", 64'(outstanding_o), 64'd0);

    // Full with a simultaneous response: pop only, push next cycle.
    for (int i = 0; i < 8; i++) grant(3 - (i % 4));
    drive(1, 2, 1, 1, 32'h1234_5678, 0);
    cycle();
    chk("fullpop_cnt7", 64'(outstanding_o), 64'd7);
    grant(2);
    chk("fullpop_cnt8", 64'(outstanding_o), 64'd8);
    for (int i = 0; i < 8; i++) respond();

    // Steady state at depth 3 with grant and response every cycle.
    for (int i = 0; i < 3; i++) grant($urandom_range(0, 3));
    for (int i = 0; i < 20; i++) begin
      drive(1, $urandom_range(0, 3), 1, 1, $urandom, 0);
      cycle();
    end
    chk("steady_cnt", 64'(outstanding_o), 64'd3);
    for (int i = 0; i < 3; i++) respond();

    // Spurious response sets a sticky error; flush clears it.
    respond();
    chk("spur_err", 64'(err_o), 64'd1);
    chk("spur_valid", 64'(rsp_valid_o), 64'd0);
    idle();
    idle();
    chk("spur_sticky", 64'(err_o), 64'd1);
    grant(1);
    drive(0, 0, 0, 0, 32'h0, 1);
    cycle();
    chk("flush_err", 64'(err_o), 64'd0);
    chk("flush_cnt", 64'(outstanding_o), 64'd0);

    // Asynchronous reset with five requests in flight.
    for (int i = 0; i < 5; i++) grant(i % 4);
    chk("prereset_cnt", 64'(outstanding_o), 64'd5);
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("areset_cnt",   64'(outstanding_o), 64'd0);
    chk("areset_valid", 64'(rsp_valid_o),   64'd0);
    chk("areset_err",   64'(err_o),         64'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    respond();
    chk("postreset_err", 64'(err_o), 64'd1);
    drive(0, 0, 0, 0, 32'h0, 1);
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic rv;
      rv = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            rv, $urandom, ($urandom_range(0, 63) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
